// File: rtl/alu_control_mdu.sv
// rtl/alu_control_mdu.sv - ALU control decoder with iterative multiply/divide unit and HI/LO
module alu_control_mdu #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       ALUFunction,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  output logic [3:0]       ALUOperation,
  output logic             JR,
  output logic             Stall,
  output logic             MDResultSel,
  output logic [WIDTH-1:0] MDResult
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     hi, lo;
  logic [WIDTH-1:0]     acc_hi, acc_lo;   // partial remainder/product high, quotient/multiplier low
  logic [WIDTH-1:0]     operand;          // divisor magnitude or multiplicand magnitude
  logic                 is_div, neg_q, neg_r, div0;

  logic             rtype, md_op, mf_hi, mf_lo;
  logic             sgn, sa, sb;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign rtype = (ALUOp == 4'b0111);
  assign md_op = rtype && (ALUFunction[5:2] == 4'b0110);
  assign mf_hi = rtype && (ALUFunction == 6'b010000);
  assign mf_lo = rtype && (ALUFunction == 6'b010010);

  // ALU operation decode from operation class and funct field
  always_comb begin
    ALUOperation = 4'b1001;
    case (ALUOp)
      4'b0111: begin
        case (ALUFunction)
          6'b100100: ALUOperation = 4'b0000;
          6'b100101: ALUOperation = 4'b0001;
          6'b100111: ALUOperation = 4'b0010;
          6'b100000: ALUOperation = 4'b0011;
          6'b100010: ALUOperation = 4'b0100;
          6'b000000: ALUOperation = 4'b0101;
          6'b000010: ALUOperation = 4'b0110;
          6'b101010: ALUOperation = 4'b1000;
          default:   ALUOperation = 4'b1001;
        endcase
      end
      4'b0100: ALUOperation = 4'b0011;
      4'b0101: ALUOperation = 4'b0001;
      4'b0110: ALUOperation = 4'b0000;
      4'b0001: ALUOperation = 4'b0100;
      4'b0010: ALUOperation = 4'b0011;
      4'b0011: ALUOperation = 4'b0011;
      4'b1000: ALUOperation = 4'b0111;
      default: ALUOperation = 4'b1001;
    endcase
  end

  assign JR          = rtype && (ALUFunction == 6'b001000);
  assign MDResultSel = mf_hi || mf_lo;
  assign MDResult    = mf_hi ? hi : (mf_lo ? lo : '0);

  // Operand magnitudes and sign bookkeeping; funct[0] set means unsigned
  assign sgn  = ~ALUFunction[0];
  assign sa   = sgn & ReadData1[WIDTH-1];
  assign sb   = sgn & ReadData2[WIDTH-1];
  assign abs1 = sa ? -ReadData1 : ReadData1;
  assign abs2 = sb ? -ReadData2 : ReadData2;

  // One shift-add multiply step and one restoring divide step
  assign mul_sum   = {1'b0, acc_hi} + ({1'b0, operand} & {(WIDTH+1){acc_lo[0]}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, operand};
  assign div_ok    = ~div_diff[WIDTH];

  // Sign correction applied when the final result is committed
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = div0 ? '1 : (neg_q ? -acc_lo : acc_lo);
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and stall; DONE never restarts even if the md op is still presented
  always_comb begin
    state_nx = state;
    Stall    = 1'b0;
    case (state)
      IDLE: begin
        if (md_op) begin
          Stall    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!reset) Stall = 1'b0;
  end

  // Datapath: latch operands, iterate, commit HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_op) begin
            is_div  <= ALUFunction[1];
            operand <= ALUFunction[1] ? abs2 : abs1;
            acc_lo  <= ALUFunction[1] ? abs1 : abs2;
            acc_hi  <= '0;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            div0    <= (ReadData2 == '0);
            cnt     <= CNT_INIT;
          end
        end
        BUSY: begin
          if (is_div) begin
            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt - CNT_LAST;
        end
        DONE: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
